// File: rtl/eth_rx_parser.sv
// eth_rx_parser: filters RMII frames by dst MAC/EtherType, buffers one payload, and checks the FCS.
// Define ETH_RX_CRC_CHECK_EN to enable the FCS check; without it, every well-formed frame is accepted.
module eth_rx_parser #(
  parameter logic [47:0] LOCAL_MAC   = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5,
  parameter int          MAX_PAYLOAD = 64
) (
  input  logic                             clk50,
  input  logic                             rst_n,
  input  logic [7:0]                       rx_byte,
  input  logic                             rx_byte_valid,
  input  logic                             frame_active,
  output logic                             pkt_valid,
  output logic [10:0]                      pkt_len,
  input  logic                             pkt_ack,
  input  logic [$clog2(MAX_PAYLOAD+4)-1:0] rd_addr,
  output logic [7:0]                       rd_data,
  output logic [7:0]                       cnt_rx_ok,
  output logic [7:0]                       cnt_crc_err,
  output logic [7:0]                       cnt_drop
);
  localparam int DEPTH = MAX_PAYLOAD + 4;
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(DEPTH + 2);
  localparam logic [WW-1:0] DEPTH_W = WW'(DEPTH);

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, HDR, DATA, CHECK, HOLD, DISCARD} state_t;

  state_t         state_q, state_d;
  logic           fa_q, busy_q, busy_d, drop_pend_q, drop_pend_d;
  logic           ucast_q, ucast_d, bcast_q, bcast_d, type_ok_q, type_ok_d;
  logic [3:0]     hcnt_q, hcnt_d;
  logic [WW-1:0]  wcnt_q, wcnt_d;
  logic           pkt_valid_q, pkt_valid_d;
  logic [10:0]    pkt_len_q, pkt_len_d;
  logic [7:0]     rd_data_q, rd_data_d;
  logic [7:0]     cnt_rx_ok_q, cnt_rx_ok_d, cnt_crc_err_q, cnt_crc_err_d, cnt_drop_q, cnt_drop_d;
  logic [7:0]     mem_q [DEPTH];
  logic           rise, fall, byte_en, start, wr_en, crc_ok, inc_ok, inc_crc, inc_drop;

  assign rise    = frame_active & ~fa_q;
  assign fall    = ~frame_active & fa_q;
  // A byte arriving on the cycle frame_active drops still belongs to the frame.
  assign byte_en = rx_byte_valid & (frame_active | fa_q);

`ifdef ETH_RX_CRC_CHECK_EN
  logic [31:0] crc_q, crc_d;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (start) crc_d = '1;
    else if (byte_en && (state_q == HDR || state_q == DATA)) crc_d = crc_step(crc_q, rx_byte);
  end

  assign crc_ok = crc_q == 32'hDEBB20E3;

  always_ff @(posedge clk50) crc_q <= !rst_n ? '1 : crc_d;
`else
  assign crc_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    drop_pend_d = 1'b0;
    ucast_d     = ucast_q;
    bcast_d     = bcast_q;
    type_ok_d   = type_ok_q;
    hcnt_d      = hcnt_q;
    wcnt_d      = wcnt_q;
    pkt_valid_d = pkt_valid_q;
    pkt_len_d   = pkt_len_q;
    start       = 1'b0;
    wr_en       = 1'b0;
    inc_ok      = 1'b0;
    inc_crc     = 1'b0;
    inc_drop    = drop_pend_q;
    case (state_q)
      WAIT_IDLE: state_d = frame_active ? WAIT_IDLE : IDLE;
      IDLE:      start = rise;
      HDR:
        if (fall) begin
          state_d     = IDLE;
          drop_pend_d = 1'b1;
        end else if (byte_en) begin
          hcnt_d = hcnt_q + 1'b1;
          if (hcnt_q < 4'd6) begin
            ucast_d = ucast_q & (rx_byte == LOCAL_MAC[8*(3'd5 - hcnt_q[2:0]) +: 8]);
            bcast_d = bcast_q & (rx_byte == 8'hFF);
          end
          if (hcnt_q == 4'd5 && !(ucast_d || bcast_d)) state_d = DISCARD;
          if (hcnt_q == 4'd12) type_ok_d = rx_byte == ETHERTYPE[15:8];
          if (hcnt_q == 4'd13) begin
            state_d = (type_ok_q && rx_byte == ETHERTYPE[7:0]) ? DATA : DISCARD;
            wcnt_d  = '0;
          end
        end
      DATA: begin
        if (byte_en) begin
          wcnt_d = wcnt_q + 1'b1;
          wr_en  = wcnt_q < DEPTH_W;
          if (wcnt_q == DEPTH_W) state_d = DISCARD;
        end
        if (fall) state_d = CHECK;
      end
      CHECK: begin
        if (wcnt_q < WW'(5) || wcnt_q > DEPTH_W) inc_drop = 1'b1;
        else if (!crc_ok) inc_crc = 1'b1;
        else begin
          inc_ok      = 1'b1;
          pkt_valid_d = 1'b1;
          pkt_len_d   = 11'(wcnt_q) - 11'd4;
        end
        state_d = inc_ok ? HOLD : IDLE;
        busy_d  = inc_ok & rise;
        start   = ~inc_ok & rise;
      end
      HOLD: begin
        if (rise) busy_d = 1'b1;
        if (fall && busy_q) begin
          busy_d      = 1'b0;
          drop_pend_d = 1'b1;
        end
        if (pkt_ack) begin
          pkt_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = frame_active ? DISCARD : IDLE;
        end
      end
      DISCARD:
        if (fall) begin
          state_d     = IDLE;
          drop_pend_d = 1'b1;
        end
      default: state_d = WAIT_IDLE;
    endcase
    if (start) begin
      state_d = HDR;
      hcnt_d  = '0;
      ucast_d = 1'b1;
      bcast_d = 1'b1;
    end
    rd_data_d     = (32'(rd_addr) < DEPTH) ? mem_q[rd_addr] : 8'd0;
    cnt_rx_ok_d   = cnt_rx_ok_q + 8'(inc_ok && cnt_rx_ok_q != 8'hFF);
    cnt_crc_err_d = cnt_crc_err_q + 8'(inc_crc && cnt_crc_err_q != 8'hFF);
    cnt_drop_d    = cnt_drop_q + 8'(inc_drop && cnt_drop_q != 8'hFF);
  end

  always_ff @(posedge clk50) if (wr_en) mem_q[wcnt_q[AW-1:0]] <= rx_byte;

  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      state_q       <= WAIT_IDLE;
      fa_q          <= 1'b0;
      busy_q        <= 1'b0;
      drop_pend_q   <= 1'b0;
      ucast_q       <= 1'b0;
      bcast_q       <= 1'b0;
      type_ok_q     <= 1'b0;
      hcnt_q        <= '0;
      wcnt_q        <= '0;
      pkt_valid_q   <= 1'b0;
      pkt_len_q     <= '0;
      rd_data_q     <= '0;
      cnt_rx_ok_q   <= '0;
      cnt_crc_err_q <= '0;
      cnt_drop_q    <= '0;
    end else begin
      state_q       <= state_d;
      fa_q          <= frame_active;
      busy_q        <= busy_d;
      drop_pend_q   <= drop_pend_d;
      ucast_q       <= ucast_d;
      bcast_q       <= bcast_d;
      type_ok_q     <= type_ok_d;
      hcnt_q        <= hcnt_d;
      wcnt_q        <= wcnt_d;
      pkt_valid_q   <= pkt_valid_d;
      pkt_len_q     <= pkt_len_d;
      rd_data_q     <= rd_data_d;
      cnt_rx_ok_q   <= cnt_rx_ok_d;
      cnt_crc_err_q <= cnt_crc_err_d;
      cnt_drop_q    <= cnt_drop_d;
    end
  end

  assign pkt_valid   = pkt_valid_q;
  assign pkt_len     = pkt_len_q;
  assign rd_data     = rd_data_q;
  assign cnt_rx_ok   = cnt_rx_ok_q;
  assign cnt_crc_err = cnt_crc_err_q;
  assign cnt_drop    = cnt_drop_q;
endmodule

// File: doc/eth_rx_parser.md
# eth_rx_parser

Consumes the recovered byte stream from the RMII receive stage (post-SFD bytes plus `frame_active`) on the 50 MHz RMII clock. Filters frames by destination MAC and EtherType, buffers the payload, and checks the FCS. It then presents one accepted payload at a time to the command decoder that drives the motor PID setpoints. Frames arriving while a payload is held are dropped and counted.

## Interface
- `LOCAL_MAC`, 48'h02_00_00_00_00_01, unicast address accepted; FF:FF:FF:FF:FF:FF is always accepted as broadcast.
- `ETHERTYPE`, 16'h88B5, only EtherType accepted.
- `MAX_PAYLOAD`, 64, payload bytes stored; buffer depth is MAX_PAYLOAD+4 (payload plus FCS).
- `clk50` in 1: 50 MHz RMII reference clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `rx_byte` in 8: received byte, first byte = dst MAC[47:40].
- `rx_byte_valid` in 1: single-cycle strobe; at most one per 4 cycles.
- `frame_active` in 1: high for the duration of a frame.
- `pkt_valid` out 1: accepted payload held in buffer.
- `pkt_len` out 11: payload byte count, valid while `pkt_valid`.
- `pkt_ack` in 1: consumer releases buffer.
- `rd_addr` in clog2(MAX_PAYLOAD+4): payload read address.
- `rd_data` out 8: buffer byte at `rd_addr`, registered.
- `cnt_rx_ok` out 8: accepted frames, saturating.
- `cnt_crc_err` out 8: FCS failures, saturating.
- `cnt_drop` out 8: frames dropped for filter mismatch, runt, oversize or busy; saturating.

## Operation
- States: WAIT_IDLE, IDLE, HDR, DATA, CHECK, HOLD, DISCARD.
- Reset sends the block to WAIT_IDLE. It leaves WAIT_IDLE for IDLE on the first cycle with `frame_active`=0, so a frame already in progress at reset release is never parsed.
- IDLE → HDR on `frame_active` rising (registered edge). The header byte counter `hcnt` is cleared and CRC is set to 32'hFFFFFFFF.
- HDR: bytes 0–5 are compared against LOCAL_MAC and broadcast, bytes 6–11 are ignored (src MAC), bytes 12–13 are compared against ETHERTYPE.
  - A mismatch is decided at byte 5 (MAC) or byte 13 (type). The block then goes to DISCARD and sets a drop pending flag.
  - After byte 13 matches, the block goes to DATA with `wcnt`=0.
- DATA: each byte is written to `buf[wcnt]` and `wcnt` increments.
  - If `wcnt` would exceed MAX_PAYLOAD+4, the block goes to DISCARD as oversize.
- CRC: reflected CRC-32, polynomial 0xEDB88320, byte-wide update on every `rx_byte_valid` from header byte 0 through the last FCS byte.
- Frame end is `frame_active` falling.
  - In HDR: runt, go to IDLE, `cnt_drop`++.
  - In DATA: go to CHECK.
  - In DISCARD: go to IDLE, `cnt_drop`++.
- CHECK (1 cycle):
  - `wcnt`<5: drop, `cnt_drop`++.
  - Otherwise, if CRC register ≠ 32'hDEBB20E3: `cnt_crc_err`++, go to IDLE.
  - Otherwise: `pkt_len`=`wcnt`−4, `pkt_valid`=1, `cnt_rx_ok`++, go to HOLD.
- HOLD: the buffer is frozen.
  - A `frame_active` rising edge in HOLD marks that frame busy-dropped. The whole frame is dropped even if `pkt_ack` arrives mid-frame, and `cnt_drop`++ at its end.
  - `pkt_ack` while `pkt_valid` clears `pkt_valid` next cycle. The block returns to IDLE, or to DISCARD if a frame is in progress.
- `pkt_ack` while `pkt_valid`=0 is ignored.
- Counters saturate at 255.
- At most one counter event occurs per frame.

## Timing
- Reset values:
  - `pkt_valid`=0
  - `pkt_len`=0
  - `rd_data`=0
  - all counters 0
  - state WAIT_IDLE
- `rd_data` latency is 1 cycle from `rd_addr`. It is valid in any state, but only meaningful while `pkt_valid`.
- Frame verdict timing:
  - `frame_active` falls at cycle T.
  - The edge is registered at T+1, and CHECK runs at T+1.
  - `pkt_valid` is 1 at T+2.
  - Counters update at T+2.
- `pkt_ack` sampled at cycle A gives `pkt_valid`=0 at A+1, and a new frame may start parsing from A+1.
- `rx_byte_valid` asserted while `frame_active`=0 is ignored.
- `rx_byte_valid` in the same cycle as the `frame_active` falling edge is processed before the end-of-frame decision.

## Configuration
- `ETH_RX_CRC_CHECK_EN` defined: FCS is checked as above and failures increment `cnt_crc_err`.
- `ETH_RX_CRC_CHECK_EN` undefined:
  - CRC logic is removed.
  - CHECK accepts any frame with `wcnt`≥5.
  - `cnt_crc_err` is tied to 0.
  - The 4 trailing bytes are still excluded from `pkt_len`.

## Test plan
- Unicast to 02:00:00:00:00:01, type 88B5, 10-byte payload 00..09, correct FCS → `pkt_valid`=1 at T+2, `pkt_len`=10, `rd_data` at addr 0..9 = 00..09, `cnt_rx_ok`=1.
- Same frame with FCS last byte XOR 01 (macro defined) → `pkt_valid` stays 0, `cnt_crc_err`=1; with the macro undefined → accepted with `pkt_len`=10.
- Broadcast dst with type 0800 → `cnt_drop`=1; dst 02:00:00:00:00:02 with type 88B5 → `cnt_drop`=2; `pkt_valid` stays 0 throughout.
- With MAX_PAYLOAD=64, a 69-byte payload → dropped as oversize, `cnt_drop`++; a 64-byte payload → accepted, `pkt_len`=64.
- Two back-to-back valid frames, no `pkt_ack` until mid second frame → first is held with contents intact, second is dropped (`cnt_drop`=1), `pkt_valid` clears one cycle after ack.
- `rst_n` pulsed low for 1 cycle in the middle of a frame → all outputs return to reset values, the rest of that frame is ignored, and the next valid frame is accepted.
